// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, load-type encodings and
// the field layout of the EXE-to-MEM bus.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 108;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_TO_DS_BUS_WD = 38;

    typedef enum logic [2:0] {
        LD_LB  = 3'd0,
        LD_LBU = 3'd1,
        LD_LH  = 3'd2,
        LD_LHU = 3'd3,
        LD_LW  = 3'd4,
        LD_LWL = 3'd5,
        LD_LWR = 3'd6,
        LD_RSV = 3'd7
    } ld_type_e;

    // Field order matches es_to_ms_bus, MSB first.
    typedef struct packed {
        logic        load_op;
        ld_type_e    ld_type;
        logic [1:0]  addr_low;
        logic [31:0] rt_value;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load byte/halfword selection, sign/zero extension and LWL/LWR merging
// of the synchronous data-SRAM read word.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  ld_type_e    ld_type,
    input  logic [1:0]  addr_low,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_value,
    output logic [31:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = rdata[7:0];
        case (addr_low)
            2'd0: ld_byte = rdata[7:0];
            2'd1: ld_byte = rdata[15:8];
            2'd2: ld_byte = rdata[23:16];
            2'd3: ld_byte = rdata[31:24];
        endcase
        // Halfword alignment is guaranteed upstream, so only addr_low[1] matters.
        ld_half = addr_low[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = rdata;
        case (ld_type)
            LD_LB:  load_data = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU: load_data = {24'd0, ld_byte};
            LD_LH:  load_data = {{16{ld_half[15]}}, ld_half};
            LD_LHU: load_data = {16'd0, ld_half};
            LD_LW:  load_data = rdata;
            LD_LWL: begin
                case (addr_low)
                    2'd0: load_data = {rdata[7:0],  rt_value[23:0]};
                    2'd1: load_data = {rdata[15:0], rt_value[15:0]};
                    2'd2: load_data = {rdata[23:0], rt_value[7:0]};
                    2'd3: load_data = rdata;
                endcase
            end
            LD_LWR: begin
                case (addr_low)
                    2'd0: load_data = rdata;
                    2'd1: load_data = {rt_value[31:24], rdata[31:8]};
                    2'd2: load_data = {rt_value[31:16], rdata[31:16]};
                    2'd3: load_data = {rt_value[31:8],  rdata[31:24]};
                endcase
            end
            LD_RSV: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches the EXE bus, finishes loads from the SRAM read
// data, and drives the WB bus plus a bypass bus back to ID.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    input  logic [31:0]                data_sram_rdata
);

    logic        ms_valid;
    logic        ms_ready_go;
    es_to_ms_t   ms_bus;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // Payload is not reset: it is only observed while ms_valid is set.
    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            ms_bus <= es_to_ms_t'(es_to_ms_bus);
        end
    end

    mem_load_align u_load_align (
        .ld_type   (ms_bus.ld_type),
        .addr_low  (ms_bus.addr_low),
        .rdata     (data_sram_rdata),
        .rt_value  (ms_bus.rt_value),
        .load_data (load_data)
    );

    assign final_result = ms_bus.load_op ? load_data : ms_bus.alu_result;

    assign ms_to_ws_bus = {ms_bus.gr_we, ms_bus.dest, final_result, ms_bus.pc};
    assign ms_to_ds_bus = {ms_valid && ms_bus.gr_we,
                           {5{ms_valid}} & ms_bus.dest,
                           final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: the driver queues hand-computed WB/ID bus
// values, a negedge monitor pops and compares them on every WB transfer.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [107:0] es_to_ms_bus;
    logic         ws_allowin;
    logic         ms_to_ws_valid;
    logic [69:0]  ms_to_ws_bus;
    logic [37:0]  ms_to_ds_bus;
    logic [31:0]  data_sram_rdata;

    typedef struct {
        logic [69:0] ws;
        logic [37:0] ds;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ws_allowin      (ws_allowin),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_to_ds_bus    (ms_to_ds_bus),
        .data_sram_rdata (data_sram_rdata)
    );

    task automatic check(input string name, input logic [69:0] act, input logic [69:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: a WB transfer happens at the next posedge whenever valid && ws_allowin.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got pc %h expected none", ms_to_ws_bus[31:0]);
                end else begin
                    e = exp_q.pop_front();
                    check("ws_bus", ms_to_ws_bus, e.ws);
                    check("ds_bus", {32'd0, ms_to_ds_bus}, {32'd0, e.ds});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // Offers one instruction to MEM; returns the number of cycles until capture.
    // The SRAM read data appears the cycle after capture, as for a real request.
    task automatic send(input logic load_op, input logic [2:0] ld, input logic [1:0] al,
                        input logic [31:0] rt, input logic we, input logic [4:0] dest,
                        input logic [31:0] alu, input logic [31:0] pc,
                        input logic [31:0] rd, input logic [31:0] exp_res,
                        input bit push, output int waited);
        exp_t e;
        bit   acc;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = {load_op, ld, al, rt, we, dest, alu, pc};
        if (push) begin
            e.ws = {we, dest, exp_res, pc};
            e.ds = {we, dest, exp_res};
            exp_q.push_back(e);
        end
        waited = 0;
        acc    = 1'b0;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = (ms_allowin === 1'b1);
            @(posedge clk);
            #1;
            waited++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL capture_timeout: got no capture expected capture of pc %h", pc);
        end
        data_sram_rdata = rd;
        es_to_ms_valid  = 1'b0;
    endtask

    initial begin
        int          w;
        logic [69:0] held;
        reset           = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        ws_allowin      = 1'b1;
        data_sram_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_valid",   {69'd0, ms_to_ws_valid}, 70'd0);
        check("reset_allowin", {69'd0, ms_allowin},     70'd1);
        check("reset_fwd",     {64'd0, ms_to_ds_bus[37:32]}, 70'd0);
        @(posedge clk);
        #1;

        // Load alignment vectors: load_op, ld_type, addr_low, rt, we, dest, alu, pc, rdata, expected
        send(1, 3'd0, 2'd3, 32'hDEADBEEF, 1, 5'd2, 32'h1000, 32'h0000_0400, 32'h8011_2233, 32'hFFFF_FF80, 1, w);
        send(1, 3'd1, 2'd3, 32'hDEADBEEF, 1, 5'd3, 32'h1000, 32'h0000_0404, 32'h8011_2233, 32'h0000_0080, 1, w);
        send(1, 3'd0, 2'd1, 32'hDEADBEEF, 1, 5'd3, 32'h1000, 32'h0000_0408, 32'h8011_2233, 32'h0000_0022, 1, w);
        send(1, 3'd2, 2'd2, 32'h0,        1, 5'd4, 32'h1000, 32'h0000_040C, 32'h8001_1234, 32'hFFFF_8001, 1, w);
        send(1, 3'd3, 2'd0, 32'h0,        1, 5'd5, 32'h1000, 32'h0000_0410, 32'h8001_1234, 32'h0000_1234, 1, w);
        send(1, 3'd4, 2'd0, 32'h0,        1, 5'd6, 32'h1000, 32'h0000_0414, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, w);
        send(1, 3'd5, 2'd0, 32'hAABBCCDD, 1, 5'd7, 32'h1000, 32'h0000_0418, 32'h4433_2211, 32'h11BB_CCDD, 1, w);
        send(1, 3'd5, 2'd1, 32'hAABBCCDD, 1, 5'd7, 32'h1000, 32'h0000_041C, 32'h4433_2211, 32'h2211_CCDD, 1, w);
        send(1, 3'd5, 2'd2, 32'hAABBCCDD, 1, 5'd7, 32'h1000, 32'h0000_0420, 32'h4433_2211, 32'h3322_11DD, 1, w);
        send(1, 3'd5, 2'd3, 32'hAABBCCDD, 1, 5'd7, 32'h1000, 32'h0000_0424, 32'h4433_2211, 32'h4433_2211, 1, w);
        send(1, 3'd6, 2'd0, 32'hAABBCCDD, 1, 5'd7, 32'h1000, 32'h0000_0428, 32'h4433_2211, 32'h4433_2211, 1, w);
        send(1, 3'd6, 2'd1, 32'hAABBCCDD, 1, 5'd7, 32'h1000, 32'h0000_042C, 32'h4433_2211, 32'hAA44_3322, 1, w);
        send(1, 3'd6, 2'd2, 32'hAABBCCDD, 1, 5'd7, 32'h1000, 32'h0000_0430, 32'h4433_2211, 32'hAABB_4433, 1, w);
        send(1, 3'd6, 2'd3, 32'hAABBCCDD, 1, 5'd7, 32'h1000, 32'h0000_0434, 32'h4433_2211, 32'hAABB_CC44, 1, w);
        send(1, 3'd7, 2'd1, 32'hAABBCCDD, 0, 5'd9, 32'h1000, 32'h0000_0438, 32'h1357_9BDF, 32'h1357_9BDF, 1, w);

        // Stall: ADDU result 5 to $8 held while WB refuses for three cycles.
        send(0, 3'd0, 2'd0, 32'h0, 1, 5'd8, 32'h5, 32'h0000_0500, 32'hFFFF_FFFF, 32'h5, 1, w);
        ws_allowin     = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = {1'b0, 3'd0, 2'd0, 32'h0, 1'b1, 5'd9, 32'h7, 32'h0000_0504};
        held = 70'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) held = ms_to_ws_bus;
            else check("stall_bus_stable", ms_to_ws_bus, held);
            check("stall_allowin", {69'd0, ms_allowin}, 70'd0);
            check("stall_ds_bus", {32'd0, ms_to_ds_bus}, {32'd0, 1'b1, 5'd8, 32'h5});
        end
        @(posedge clk);
        #1;
        ws_allowin = 1'b1;
        send(0, 3'd0, 2'd0, 32'h0, 1, 5'd9, 32'h7, 32'h0000_0504, 32'h0, 32'h7, 1, w);
        check("release_capture_cycles", 70'(w), 70'd1);

        // Reset while a load sits in MEM: that load must never reach WB.
        @(posedge clk);
        #1;
        ws_allowin = 1'b0;
        send(1, 3'd4, 2'd0, 32'h0, 1, 5'd10, 32'h0, 32'h0000_0600, 32'h1234_5678, 32'h1234_5678, 0, w);
        @(negedge clk);
        check("pre_reset_fwd_we", {69'd0, ms_to_ds_bus[37]}, 70'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_valid",    {69'd0, ms_to_ws_valid},   70'd0);
        check("post_reset_fwd_we",   {69'd0, ms_to_ds_bus[37]}, 70'd0);
        check("post_reset_fwd_dest", {65'd0, ms_to_ds_bus[36:32]}, 70'd0);
        @(posedge clk);
        #1;
        ws_allowin = 1'b1;

        // Back-to-back stream: one capture per cycle.
        for (int i = 0; i < 4; i++) begin
            send(0, 3'd0, 2'd0, 32'h0, 1, 5'(11 + i), 32'h100 + 32'(i), 32'h0000_0700 + 32'(4 * i),
                 32'h0, 32'h100 + 32'(i), 1, w);
            check("stream_capture_cycles", 70'(w), 70'd1);
        end
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 70'(exp_q.size()), 70'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
